branch_hazard_ctrl: RTL and testbench

Sequencing controller for the ID-stage branch comparator in the 5-stage pipeline. Decodes the 3-bit branch code, detects read-after-write hazards on the comparator operands, and stalls ID via a small FSM until the operands are available. Selects forwarding sources for the comparator's busA/busB, then drives PC redirect and IF/ID flush from the comparator's taken flag. It also keeps branch, taken and stall event counters for performance debug.

---
 rtl/branch_hazard_ctrl.sv | 99 +++++++++
 tb/tb_branch_hazard_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch hazard stall FSM, comparator forwarding, redirect/flush and event counters
module branch_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_stall,
  input  logic [2:0]  id_branch,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        branch_ok,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        pc_src,
  output logic [31:0] br_count,
  output logic [31:0] taken_count,
  output logic [31:0] stall_count
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_d;
  logic cnt, cnt_d;
  logic stall, resolve;
  logic [31:0] br_q, taken_q, stall_q;
  logic br_valid, uses_rt, live_a, live_b;
  logic [1:0] need_a, need_b, need, fa, fb;
  function automatic logic [1:0] need_of(input logic live, input logic [4:0] s,
      input logic exw, input logic exm, input logic [4:0] exd,
      input logic mw, input logic mm, input logic [4:0] md);
    return !live ? 2'd0 : (exw && exd == s) ? (exm ? 2'd2 : 2'd1) : (mw && mm && md == s) ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] fwd_of(input logic [4:0] r, input logic mw, input logic mm,
      input logic [4:0] md, input logic ww, input logic [4:0] wd);
    return (r == 5'd0) ? 2'b00 : (mw && !mm && md == r) ? 2'b01 : (ww && wd == r) ? 2'b10 : 2'b00;
  endfunction
  assign br_valid = (id_branch != 3'b000) && (id_branch != 3'b111);
  assign uses_rt  = (id_branch == 3'b001) || (id_branch == 3'b010);
  assign live_a   = br_valid && (id_rs != 5'd0);
  assign live_b   = br_valid && uses_rt && (id_rt != 5'd0);
  assign need_a   = need_of(live_a, id_rs, ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd);
  assign need_b   = need_of(live_b, id_rt, ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd);
  assign need     = (need_a > need_b) ? need_a : need_b;
  assign fa       = fwd_of(id_rs, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
  assign fb       = uses_rt ? fwd_of(id_rt, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd) : 2'b00;
  // The RUN cycle that detects a hazard is itself the first stall cycle; STALL covers any remainder.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    stall   = 1'b0;
    resolve = 1'b0;
    if (!ext_stall) begin
      if (state == STALL) begin
        stall   = 1'b1;
        state_d = cnt ? STALL : RUN;
        cnt_d   = 1'b0;
      end else if (br_valid && need != 2'd0) begin
        stall   = 1'b1;
        state_d = need[1] ? STALL : RUN;
        cnt_d   = 1'b0;
      end else begin
        resolve = br_valid;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= 1'b0;
      br_q    <= '0;
      taken_q <= '0;
      stall_q <= '0;
    end else if (!ext_stall) begin
      state   <= state_d;
      cnt     <= cnt_d;
      br_q    <= br_q + {31'd0, resolve};
      taken_q <= taken_q + {31'd0, resolve && branch_ok};
      stall_q <= stall_q + {31'd0, stall};
    end
  end
  assign stall_pc    = !reset && (stall || ext_stall);
  assign stall_ifid  = stall_pc;
  assign bubble_idex = !reset && stall;
  assign pc_src      = !reset && resolve && branch_ok;
  assign flush_ifid  = pc_src;
  assign fwd_a       = (!reset && resolve) ? fa : 2'b00;
  assign fwd_b       = (!reset && resolve) ? fb : 2'b00;
  assign br_count    = reset ? '0 : br_q;
  assign taken_count = reset ? '0 : taken_q;
  assign stall_count = reset ? '0 : stall_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed vector table plus multi-cycle stall/freeze/reset sequences
module tb_branch_hazard_ctrl;
  logic clk = 0, reset, ext_stall, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, branch_ok;
  logic [2:0] id_branch;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid, pc_src;
  logic [31:0] br_count, taken_count, stall_count;
  int checks = 0, errors = 0;
  int exp_br = 0, exp_tk = 0, exp_st = 0;
  always #5 clk = ~clk;
  branch_hazard_ctrl dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .branch_ok(branch_ok),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .pc_src(pc_src), .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
  );
  typedef struct {
    logic [2:0] br; logic [4:0] rs, rt;
    logic exw, exm; logic [4:0] exd;
    logic mw, mm; logic [4:0] md;
    logic ww; logic [4:0] wd; logic ok;
    logic [1:0] fa, fb; logic st, res, pc;
  } vec_t;
  vec_t vt [14];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic idle();
    ext_stall = 0; id_branch = 0; id_rs = 0; id_rt = 0; branch_ok = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string n, input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic bub, input logic pc);
    #2;
    chk({n, "_fwd_a"}, 32'(fwd_a), 32'(fa));
    chk({n, "_fwd_b"}, 32'(fwd_b), 32'(fb));
    chk({n, "_stall_pc"}, 32'(stall_pc), 32'(st));
    chk({n, "_stall_ifid"}, 32'(stall_ifid), 32'(st));
    chk({n, "_bubble"}, 32'(bubble_idex), 32'(bub));
    chk({n, "_pc_src"}, 32'(pc_src), 32'(pc));
    chk({n, "_flush"}, 32'(flush_ifid), 32'(pc));
  endtask
  task automatic counters(input string n, input int b, input int t, input int s);
    chk({n, "_br_count"}, br_count, b);
    chk({n, "_taken_count"}, taken_count, t);
    chk({n, "_stall_count"}, stall_count, s);
  endtask
  initial begin
    //        br  rs  rt exw exm exd mw mm md ww wd ok  fa fb st res pc
    vt[0]  = '{1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    vt[1]  = '{1, 5, 6, 0, 0, 0, 1, 0, 5, 1, 6, 0, 1, 2, 0, 1, 0};
    vt[2]  = '{2, 5, 6, 1, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[3]  = '{3, 7, 7, 0, 0, 0, 1, 0, 7, 0, 0, 1, 1, 0, 0, 1, 1};
    vt[4]  = '{4, 3, 9, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[5]  = '{5, 4, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[6]  = '{6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    vt[7]  = '{7, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1};
    vt[10] = '{1, 8, 8, 0, 0, 0, 1, 1, 8, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[11] = '{1, 8, 8, 0, 0, 0, 1, 0, 8, 1, 8, 1, 1, 1, 0, 1, 1};
    vt[12] = '{2, 2, 3, 0, 1, 2, 0, 0, 2, 1, 3, 0, 0, 2, 0, 1, 0};
    vt[13] = '{1, 5, 6, 0, 0, 0, 1, 1, 9, 1, 5, 0, 2, 0, 0, 1, 0};
    idle();
    reset = 1;
    tick();
    tick();
    id_branch = 1; id_rs = 5; id_rt = 6; branch_ok = 1;
    outs("in_reset", 0, 0, 0, 0, 0);
    counters("in_reset", 0, 0, 0);
    reset = 0;
    idle();
    #2;
    counters("after_reset", 0, 0, 0);
    foreach (vt[i]) begin
      id_branch = vt[i].br; id_rs = vt[i].rs; id_rt = vt[i].rt;
      ex_regwrite = vt[i].exw; ex_memread = vt[i].exm; ex_rd = vt[i].exd;
      mem_regwrite = vt[i].mw; mem_memread = vt[i].mm; mem_rd = vt[i].md;
      wb_regwrite = vt[i].ww; wb_rd = vt[i].wd; branch_ok = vt[i].ok;
      outs($sformatf("vec%0d", i), vt[i].fa, vt[i].fb, vt[i].st, vt[i].st, vt[i].pc);
      exp_br += int'(vt[i].res); exp_tk += int'(vt[i].pc); exp_st += int'(vt[i].st);
      tick();
    end
    idle();
    #2;
    counters("table", exp_br, exp_tk, exp_st);
    // ALU producer in EX: one stall, then forward from EX/MEM
    id_branch = 2; id_rs = 5; id_rt = 6; ex_regwrite = 1; ex_rd = 5;
    outs("alu_stall", 0, 0, 1, 1, 0);
    tick();
    idle(); id_branch = 2; id_rs = 5; id_rt = 6; mem_regwrite = 1; mem_rd = 5; branch_ok = 1;
    outs("alu_resolve", 1, 0, 0, 0, 1);
    tick();
    idle(); #2;
    counters("alu", 10, 6, 4);
    // Load in EX: two stalls, then forward from MEM/WB
    id_branch = 3; id_rs = 7; ex_regwrite = 1; ex_memread = 1; ex_rd = 7;
    outs("ld_stall0", 0, 0, 1, 1, 0);
    tick();
    idle(); id_branch = 3; id_rs = 7; mem_regwrite = 1; mem_memread = 1; mem_rd = 7;
    outs("ld_stall1", 0, 0, 1, 1, 0);
    tick();
    idle(); id_branch = 3; id_rs = 7; wb_regwrite = 1; wb_rd = 7;
    outs("ld_resolve", 2, 0, 0, 0, 0);
    tick();
    idle(); #2;
    counters("load", 11, 6, 6);
    // Load hazard frozen by ext_stall for 3 cycles inside the stall window
    id_branch = 3; id_rs = 7; ex_regwrite = 1; ex_memread = 1; ex_rd = 7;
    outs("frz_stall0", 0, 0, 1, 1, 0);
    tick();
    idle(); id_branch = 3; id_rs = 7; mem_regwrite = 1; mem_memread = 1; mem_rd = 7; branch_ok = 1;
    ext_stall = 1;
    for (int k = 0; k < 3; k++) begin
      outs($sformatf("frz_hold%0d", k), 0, 0, 1, 0, 0);
      tick();
    end
    ext_stall = 0;
    outs("frz_stall1", 0, 0, 1, 1, 0);
    tick();
    idle(); id_branch = 3; id_rs = 7; wb_regwrite = 1; wb_rd = 7; branch_ok = 1;
    outs("frz_resolve", 2, 0, 0, 0, 1);
    tick();
    idle(); #2;
    counters("freeze", 12, 7, 8);
    // Reset while in STALL
    id_branch = 1; id_rs = 7; id_rt = 6; ex_regwrite = 1; ex_memread = 1; ex_rd = 7;
    outs("rst_stall0", 0, 0, 1, 1, 0);
    tick();
    reset = 1;
    outs("rst_high", 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    idle();
    outs("rst_after", 0, 0, 0, 0, 0);
    counters("rst_after", 0, 0, 0);
    id_branch = 1; id_rs = 5; id_rt = 6; branch_ok = 1;
    outs("rst_branch", 0, 0, 0, 0, 1);
    tick();
    idle(); #2;
    counters("rst_branch", 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
